// File: rtl/f32_mult_arbiter.sv
// Round-robin front end sharing one f32_mult between N_REQ requesters.
// One operation in flight: accept, pulse start, wait for done, hand the result back.
module f32_mult_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*32-1:0]  req_a,
   input  logic [N_REQ*32-1:0]  req_b,
   output logic [N_REQ-1:0]     rsp_valid,
   input  logic [N_REQ-1:0]     rsp_ready,
   output logic [31:0]          rsp_p,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_overflow,
   output logic                 rsp_underflow,
   output logic                 mult_start,
   output logic [31:0]          mult_a,
   output logic [31:0]          mult_b,
   input  logic                 mult_done,
   input  logic [31:0]          mult_p,
   input  logic                 mult_overflow,
   input  logic                 mult_underflow,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win;
   logic [ID_W-1:0] idx;
   logic            any_valid;

   // First valid requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      any_valid = 1'b0;
      win       = '0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % N_REQ);
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            win       = idx;
         end
      end
   end

   // Held low through reset so no requester sees an accept while rst_n is asserted.
   assign req_ready  = (rst_n && state == IDLE && any_valid) ? (N_REQ'(1) << win) : '0;
   assign rsp_valid  = (state == RESP) ? (N_REQ'(1) << rsp_id) : '0;
   assign mult_start = (state == ISSUE);
   assign busy       = (state != IDLE);

   // NOTE: all state below uses non-blocking assignment so every register
   // samples pre-edge values and the update order inside the block is irrelevant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         mult_a        <= '0;
         mult_b        <= '0;
         rsp_p         <= '0;
         rsp_id        <= '0;
         rsp_overflow  <= 1'b0;
         rsp_underflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  mult_a        <= req_a[32*win +: 32];
                  mult_b        <= req_b[32*win +: 32];
                  rsp_id        <= win;
                  rsp_overflow  <= 1'b0;
                  rsp_underflow <= 1'b0;
                  state         <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // Flags arrive a cycle ahead of done, so accumulate rather than sample.
               rsp_overflow  <= rsp_overflow  | mult_overflow;
               rsp_underflow <= rsp_underflow | mult_underflow;
               if (mult_done) begin
                  rsp_p <= mult_p;
                  state <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready[rsp_id]) begin
                  ptr   <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_f32_mult_arbiter.sv
// Bench for f32_mult_arbiter: behavioural multiplier stub, per-requester operand
// queues, and a scoreboard of expected responses filled at accept time.
module tb_f32_mult_arbiter;
   localparam int N    = 4;
   localparam int ID_W = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*32-1:0] req_a, req_b;
   logic [31:0]     rsp_p, mult_a, mult_b, mult_p;
   logic [ID_W-1:0] rsp_id;
   logic            rsp_overflow, rsp_underflow, mult_start, mult_done;
   logic            mult_overflow, mult_underflow, busy;

   f32_mult_arbiter #(.N_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id),
      .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
      .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_done(mult_done), .mult_p(mult_p),
      .mult_overflow(mult_overflow), .mult_underflow(mult_underflow), .busy(busy)
   );

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     p;
      logic            ov;
      logic            un;
      int              lat;
      int              t_acc;
   } exp_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t sb[$];
   int   exp_grant[$];

   logic [31:0] op_a [N][16];
   logic [31:0] op_b [N][16];
   logic [31:0] op_p [N][16];
   logic        op_ov[N][16];
   logic        op_un[N][16];
   int          op_lat[N][16];
   int          head[N];
   int          tail[N];
   logic        acc_flag[N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
             (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
   endfunction

   // Truncating single-precision multiply, denormals flushed. Returns {ov, un, p}.
   function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] prod;
      logic [22:0] m;
      int          e;
      s = a[31] ^ b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
         return {2'b00, 32'h7FC00000};
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {2'b00, 32'h7FC00000};
         return {2'b00, s, 8'hFF, 23'h0};
      end
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {2'b00, s, 31'h0};
      prod = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (prod[47]) begin
         m = prod[46:24];
         e++;
      end else begin
         m = prod[45:23];
      end
      if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
      if (e <= 0)   return {2'b01, s, 31'h0};
      return {2'b00, s, e[7:0], m};
   endfunction

   // Multiplier stub: done 4 cycles after start (3 for special operands),
   // exception flags pulse one cycle before done.
   int          scnt;
   logic [33:0] s_res;
   logic        spur = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt  <= 0;
         s_res <= '0;
      end else if (mult_start) begin
         s_res <= fmul(mult_a, mult_b);
         scnt  <= is_special(mult_a, mult_b) ? 3 : 4;
      end else if (scnt > 0) begin
         scnt <= scnt - 1;
      end
   end
   assign mult_p         = s_res[31:0];
   assign mult_overflow  = (scnt == 2) && s_res[33];
   assign mult_underflow = (scnt == 2) && s_res[32];
   assign mult_done      = (scnt == 1) || spur;

   task automatic push_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic ov, input logic un, input int lat);
      op_a[r][tail[r]]   = a;
      op_b[r][tail[r]]   = b;
      op_p[r][tail[r]]   = p;
      op_ov[r][tail[r]]  = ov;
      op_un[r][tail[r]]  = un;
      op_lat[r][tail[r]] = lat;
      tail[r]++;
   endtask

   task automatic push_model(input int r, input logic [31:0] a, input logic [31:0] b);
      logic [33:0] res;
      res = fmul(a, b);
      push_op(r, a, b, res[31:0], res[33], res[32], is_special(a, b) ? 5 : 6);
   endtask

   // Requester driver: hold each operand pair until it is accepted.
   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
         acc_flag[i] = 1'b0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
               head[i]++;
               acc_flag[i] = 1'b0;
            end
            req_valid[i] = (head[i] < tail[i]);
            req_a[32*i +: 32] = req_valid[i] ? op_a[i][head[i]] : 32'h0;
            req_b[32*i +: 32] = req_valid[i] ? op_b[i][head[i]] : 32'h0;
         end
      end
   end

   // Monitor on the falling edge: accepts, start timing, responses.
   initial begin
      logic prev_rv;
      int   last_acc;
      int   g;
      exp_t e;
      prev_rv  = 1'b0;
      last_acc = -10;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rv = 1'b0;
         end else begin
            if (|(req_valid & req_ready)) begin
               g = 0;
               for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
               check("ready_onehot", 32'(req_ready), 32'(N'(1) << g));
               if (exp_grant.size() > 0) check("grant", g, exp_grant.pop_front());
               e.id    = ID_W'(g);
               e.p     = op_p[g][head[g]];
               e.ov    = op_ov[g][head[g]];
               e.un    = op_un[g][head[g]];
               e.lat   = op_lat[g][head[g]];
               e.t_acc = cyc;
               sb.push_back(e);
               acc_flag[g] = 1'b1;
               last_acc = cyc;
            end
            if (busy) check("ready_while_busy", 32'(req_ready), 0);
            if (mult_start) check("start_cycle", cyc, last_acc + 1);
            if (rsp_valid != 0) begin
               if (sb.size() == 0) begin
                  check("unexpected_rsp", 32'(rsp_valid), 0);
               end else begin
                  if (!prev_rv) check("rsp_latency", cyc - sb[0].t_acc, sb[0].lat);
                  if (rsp_ready[rsp_id]) begin
                     e = sb.pop_front();
                     check("rsp_id", 32'(rsp_id), 32'(e.id));
                     check("rsp_valid", 32'(rsp_valid), 32'(N'(1) << e.id));
                     check("rsp_p", rsp_p, e.p);
                     check("rsp_overflow", 32'(rsp_overflow), 32'(e.ov));
                     check("rsp_underflow", 32'(rsp_underflow), 32'(e.un));
                  end
               end
            end
            prev_rv = (rsp_valid != 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic ops_pending();
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while ((sb.size() != 0 || busy || ops_pending()) && k < budget) begin
         tick(1);
         k++;
      end
      if (k >= budget) check("timeout_done", 1, 0);
   endtask

   task automatic wait_busy(input int budget);
      int k;
      k = 0;
      while (!busy && k < budget) begin
         tick(1);
         k++;
      end
      if (k >= budget) check("timeout_busy", 1, 0);
   endtask

   initial begin
      logic [31:0] a, b;
      logic [N-1:0] hv;
      logic [31:0] hp;
      logic [ID_W-1:0] hid;
      int k;
      rsp_ready = '1;
      tick(2);
      check("reset_busy", 32'(busy), 0);
      check("reset_rsp_valid", 32'(rsp_valid), 0);
      check("reset_mult_start", 32'(mult_start), 0);
      check("reset_mult_a", mult_a, 0);
      check("reset_rsp_p", rsp_p, 0);
      rst_n = 1'b1;
      tick(1);

      // Single requester, 2.0 * 3.0.
      push_op(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 6);
      wait_done(100);

      // All requesters valid continuously from reset: strict rotation.
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      exp_grant = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            k = 4 * r + i;
            a = 32'h3F800000 + 32'(k) * 32'h00130000;
            b = (k == 5) ? 32'h0 : 32'h40000000 + 32'(k) * 32'h00250000;
            push_model(i, a, b);
         end
      end
      wait_done(400);
      check("grants_consumed", exp_grant.size(), 0);

      // Exception flags accumulated ahead of done, cleared for the next operation.
      push_op(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 6);
      wait_done(100);
      push_op(1, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 6);
      wait_done(100);
      push_op(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 6);
      wait_done(100);

      // NaN operand takes the short path.
      push_op(3, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 5);
      wait_done(100);

      // Response back-pressure on requester 2 while requester 1 waits.
      rsp_ready[2] = 1'b0;
      exp_grant = '{2, 1};
      push_op(2, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0, 6);
      wait_busy(20);
      push_op(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 6);
      k = 0;
      while (!rsp_valid[2] && k < 50) begin
         tick(1);
         k++;
      end
      if (k >= 50) check("timeout_rsp2", 1, 0);
      hv  = rsp_valid;
      hp  = rsp_p;
      hid = rsp_id;
      check("stall_rsp_p", hp, 32'h41100000);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("stall_rsp_valid", 32'(rsp_valid), 32'(hv));
         check("stall_rsp_p_hold", rsp_p, hp);
         check("stall_rsp_id", 32'(rsp_id), 32'(hid));
         check("stall_req_ready", 32'(req_ready), 0);
         check("stall_mult_start", 32'(mult_start), 0);
      end
      rsp_ready[2] = 1'b1;
      wait_done(100);

      // Stray done while idle is ignored.
      spur = 1'b1;
      tick(1);
      spur = 1'b0;
      check("stray_done_busy", 32'(busy), 0);
      check("stray_done_rsp", 32'(rsp_valid), 0);

      // Reset in the middle of WAIT; the aborted request is re-presented.
      push_op(3, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 6);
      wait_busy(20);
      tick(2);
      check("pre_reset_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("wait_rst_busy", 32'(busy), 0);
      check("wait_rst_rsp_valid", 32'(rsp_valid), 0);
      check("wait_rst_mult_start", 32'(mult_start), 0);
      check("wait_rst_mult_a", mult_a, 0);
      check("wait_rst_mult_b", mult_b, 0);
      check("wait_rst_rsp_id", 32'(rsp_id), 0);
      sb.delete();
      exp_grant = '{0, 3};
      push_op(0, 32'h40800000, 32'h40000000, 32'h41000000, 1'b0, 1'b0, 6);
      push_op(3, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 6);
      tick(2);
      check("rst_req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      wait_done(200);
      check("post_rst_grants", exp_grant.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/f32_mult_arbiter.md
# f32_mult_arbiter

Round-robin scheduler that shares one `f32_mult` instance between `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues one `start` pulse per operation. It holds the operands stable while the multiplier runs, captures the product and the exception flags, and returns them to the originating requester over a per-requester response handshake. It is the sole master of the multiplier's `start`, `a` and `b` inputs.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(N_REQ)`, width of requester index
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  per-requester operand valid
- `req_ready`  out  N_REQ  per-requester accept, at most one bit high
- `req_a`, `req_b`  in  N_REQ*32  flattened operands, requester i at `[32*i+31:32*i]`
- `rsp_valid`  out  N_REQ  one-hot response valid
- `rsp_ready`  in  N_REQ  per-requester response accept
- `rsp_p`  out  32  product
- `rsp_id`  out  ID_W  index of the requester being answered
- `rsp_overflow`, `rsp_underflow`  out  1  exception flags for this product
- `mult_start`  out  1  to multiplier `start`
- `mult_a`, `mult_b`  out  32  to multiplier `a`, `b`
- `mult_done`  in  1  from multiplier `done`
- `mult_p`  in  32  from multiplier `p`
- `mult_overflow`, `mult_underflow`  in  1  from multiplier `overflow_o`/`underflow_o`
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Winner g = first i with `req_valid[i]`, searching ptr, ptr+1, … mod N_REQ.
  - `req_ready[g]`=1 combinationally; transfer occurs when `req_valid[g] && req_ready[g]`.
  - On transfer, register `req_a`/`req_b` slice g into `mult_a`/`mult_b`, store g in `rsp_id`, clear the flag accumulators, and go to ISSUE.
  - With no `req_valid`: stay in IDLE, all `req_ready`=0.
- **ISSUE:** `mult_start`=1 for exactly this cycle; go to WAIT.
- **WAIT:**
  - Each cycle, OR `mult_overflow` into `rsp_overflow` and `mult_underflow` into `rsp_underflow`. The multiplier pulses these flags one cycle before `done`, so they are accumulated and not sampled at `done`.
  - On `mult_done`, register `mult_p` into `rsp_p` (OR the flags that cycle as well) and go to RESP.
  - Hold `mult_start`=0 and `mult_a`/`mult_b` stable.
- **RESP:**
  - `rsp_valid[rsp_id]`=1. `rsp_p`, the flags and `rsp_id` are stable.
  - When `rsp_ready[rsp_id]` is high: ptr ← (rsp_id+1) mod N_REQ, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `mult_a`/`mult_b` stay stable from ISSUE until the next accept. The multiplier samples them combinationally after `start`.
- The multiplier is guaranteed idle at ISSUE, because its DONE→IDLE transition coincides with this block's WAIT→RESP.
- Requesters must hold `req_valid` and operands until accepted. Dropping `req_valid` before accept is legal and removes the request.
- Exactly one operation is in flight; no queuing; `req_ready`=0 outside IDLE.
- Latency is data-dependent: the block waits for `mult_done` and never counts cycles.

## Timing
- **Reset:** asynchronous on `rst_n` low, in any state including mid-WAIT.
  - State→IDLE, ptr→0.
  - `req_ready`, `rsp_valid`, `mult_start`, `busy`, `rsp_overflow`, `rsp_underflow` → 0.
  - `mult_a`, `mult_b`, `rsp_p`, `rsp_id` → 0.
  - An aborted request is not answered; the requester re-presents it.
- Accept in cycle T → `mult_start` at T+1.
- With `f32_mult`:
  - Normal operands: `mult_done` at T+5, `rsp_valid` from T+6.
  - Zero/inf/NaN/denormal operands: `mult_done` at T+4, `rsp_valid` from T+5.
- Response accepted in cycle R → IDLE at R+1 → earliest next accept at R+1.
- Minimum period per operation: 7 cycles (normal operands, `rsp_ready` already high).
- A `mult_done` outside WAIT is ignored.
- ptr wraps N_REQ-1 → 0.
- A requester answered at R cannot win at R+1 if any other `req_valid` is high.

## Test plan
- Requester 0 only, a=0x40000000, b=0x40400000 → a single 1-cycle `mult_start` at T+1; `rsp_valid`=4'b0001 at T+6; `rsp_p`=0x40C00000, `rsp_id`=0, both flags 0.
- All four `req_valid` high continuously, `rsp_ready` all 1, from reset → grant order 0,1,2,3,0,1; exactly one `req_ready` bit high per accept; each response carries its own operands' product.
- Behavioural multiplier stub pulses `mult_overflow` one cycle before `mult_done` with `mult_p`=0x7F800000 → `rsp_overflow`=1, `rsp_underflow`=0, `rsp_p`=0x7F800000. Repeat with `mult_underflow` → `rsp_underflow`=1. The next operation's flags start at 0.
- Requester 2 answered with `rsp_ready[2]` low for 5 cycles while requester 1 is valid → `rsp_valid`, `rsp_p` and `rsp_id` stable for 5 cycles; no `req_ready`, no `mult_start`; requester 1 is then granted.
- a=0x7FC00000, b=0x3F800000 → `rsp_valid` at T+5, `rsp_p`=0x7FC00000, flags 0.
- `rst_n` low during WAIT, requester 3 still valid → all outputs 0 immediately; after release, requester 0 (ptr=0) wins if valid, otherwise requester 3 is regranted.
